// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: instruction fetch front end. Issues in-order fetch requests
// to memory, buffers returned instructions with their PCs in a DEPTH-entry
// queue and hands them to decode. A kill redirects fetch and discards all
// responses still in flight.
// Optional feature macro: CPU_FETCH_BYPASS_EN -- when defined, a kept response
// arriving at an empty queue is presented to decode in the same cycle.
module cpu_fetch_queue #(
    parameter int                INSN_W   = 48,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    output logic [ADDR_W-1:0] hatch_address,
    output logic              hatch_req,
    input  logic              hatch_gnt,
    input  logic              hatch_rvalid,
    input  logic [INSN_W-1:0] hatch_instruction,
    output logic              valid_1a,
    output logic [INSN_W-1:0] instruction_1a,
    output logic [ADDR_W-1:0] pc_1a,
    input  logic              stall_2a,
    input  logic              kill_4a,
    input  logic [ADDR_W-1:0] branch_target_4a
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = PW + 1;
    localparam logic [CW:0]       DEPTH_V = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [INSN_W-1:0] r_insn_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];

    logic          w_active;
    logic          w_empty;
    logic [CW:0]   w_in_use;
    logic          w_grant;
    logic          w_ret;
    logic          w_keep;
    logic          w_bypass;
    logic          w_bypass_take;
    logic          w_push;
    logic          w_pop;

    assign w_active = !rst_b && !kill_4a;
    assign w_empty  = (r_count == '0);
    // Queue slots already claimed: buffered entries plus responses in flight.
    assign w_in_use = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_grant  = hatch_req && hatch_gnt;
    // Any response retires one outstanding request, whether kept or dropped.
    assign w_ret    = !rst_b && hatch_rvalid && (r_outstanding != '0);
    assign w_keep   = w_ret && !kill_4a && (r_drop == '0);

`ifdef CPU_FETCH_BYPASS_EN
    assign w_bypass = w_keep && w_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_bypass_take = w_bypass && !stall_2a;
    assign w_push        = w_keep && !w_bypass_take;
    assign w_pop         = w_active && !w_empty && !stall_2a;

    // Request and decode-side outputs; everything held at zero in reset.
    always_comb begin
        hatch_req      = 1'b0;
        hatch_address  = r_fetch_pc;
        valid_1a       = 1'b0;
        instruction_1a = '0;
        pc_1a          = '0;
        if (!rst_b) begin
            hatch_req = !kill_4a && (w_in_use < DEPTH_V);
            valid_1a  = !kill_4a && (!w_empty || w_bypass);
            if (w_empty && w_bypass) begin
                instruction_1a = hatch_instruction;
                pc_1a          = r_resp_pc;
            end else begin
                instruction_1a = r_insn_mem[r_head];
                pc_1a          = r_pc_mem[r_head];
            end
        end
    end

    // Control state: PCs, in-flight/drop counters and queue pointers.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_ret);
            if (kill_4a) begin
                r_fetch_pc <= branch_target_4a;
                r_resp_pc  <= branch_target_4a;
                // Every request still unreturned after this cycle belongs to
                // the killed stream; earlier pending drops are a subset of them.
                r_drop     <= r_outstanding - CW'(w_ret);
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
            end else begin
                if (w_grant)
                    r_fetch_pc <= r_fetch_pc + STEP_V;
                if (w_keep)
                    r_resp_pc <= r_resp_pc + STEP_V;
                if (w_ret && (r_drop != '0))
                    r_drop <= r_drop - CW'(1);
                if (w_push)
                    r_tail <= r_tail + PW'(1);
                if (w_pop)
                    r_head <= r_head + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // Queue storage; contents are only meaningful below r_count, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_insn_mem[r_tail] <= hatch_instruction;
            r_pc_mem[r_tail]   <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Bench for cpu_fetch_queue: in-order memory responder with programmable
// latency, a queue-level reference model checked every cycle, and directed
// scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_cpu_fetch_queue;

    localparam int DEPTH = 4;
`ifdef CPU_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] hatch_address;
    logic        hatch_req;
    logic        hatch_gnt;
    logic        hatch_rvalid;
    logic [47:0] hatch_instruction;
    logic        valid_1a;
    logic [47:0] instruction_1a;
    logic [31:0] pc_1a;
    logic        stall_2a;
    logic        kill_4a;
    logic [31:0] branch_target_4a;

    always #5 clk = ~clk;

    cpu_fetch_queue #(
        .INSN_W(48), .ADDR_W(32), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .hatch_address(hatch_address), .hatch_req(hatch_req), .hatch_gnt(hatch_gnt),
        .hatch_rvalid(hatch_rvalid), .hatch_instruction(hatch_instruction),
        .valid_1a(valid_1a), .instruction_1a(instruction_1a), .pc_1a(pc_1a),
        .stall_2a(stall_2a), .kill_4a(kill_4a), .branch_target_4a(branch_target_4a)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int grants = 0;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mem_q[$];
    logic [31:0] acc_pc[$];
    logic [47:0] acc_insn[$];
    int          acc_cyc[$];

    // Memory contents: derived from the address so every PC has a unique word.
    function automatic logic [47:0] mem_f(input logic [31:0] a);
        return {a[15:0], a ^ 32'hDEADBEEF};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] accp(input int i);
        if (i < acc_pc.size()) return {32'h0, acc_pc[i]};
        return '1;
    endfunction

    function automatic logic [63:0] acci(input int i);
        if (i < acc_insn.size()) return {16'h0, acc_insn[i]};
        return '1;
    endfunction

    function automatic int acy(input int i);
        if (i < acc_cyc.size()) return acc_cyc[i];
        return -1000;
    endfunction

    task automatic clear_log();
        acc_pc.delete();
        acc_insn.delete();
        acc_cyc.delete();
    endtask

    // Apply inputs for this cycle; the memory answers the oldest due request.
    task automatic set_in(input bit rst, input bit gnt, input bit stall, input bit kill,
                          input logic [31:0] tgt);
        rst_b             = rst;
        hatch_gnt         = gnt;
        stall_2a          = stall;
        kill_4a           = kill;
        branch_target_4a  = tgt;
        hatch_rvalid      = 1'b0;
        hatch_instruction = '0;
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            hatch_rvalid      = 1'b1;
            hatch_instruction = mem_f(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    endtask

    // Record grants seen this cycle, then advance to just after the next edge.
    task automatic end_cycle();
        mreq_t r;
        @(negedge clk);
        if (rst_b) begin
            mem_q.delete();
        end else if (hatch_req && hatch_gnt) begin
            r.addr = hatch_address;
            r.due  = cyc + lat;
            mem_q.push_back(r);
            grants++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit rst, input bit gnt, input bit stall, input bit kill,
                         input logic [31:0] tgt);
        set_in(rst, gnt, stall, kill, tgt);
        end_cycle();
    endtask

    // Reference model: fetch PC, response PC, buffered PCs and a keep/drop
    // flag per in-flight request.
    logic [31:0] m_fpc;
    logic [31:0] m_rpc;
    logic [31:0] m_q[$];
    bit          m_pend[$];

    always @(negedge clk) begin : compare
        bit          kept, byp, e_req, e_valid, consumed;
        logic [31:0] e_pc;
        if (rst_b) begin
            chk("reset_hatch_req", {63'h0, hatch_req}, 64'h0);
            chk("reset_valid_1a", {63'h0, valid_1a}, 64'h0);
            chk("reset_pc_1a", {32'h0, pc_1a}, 64'h0);
            chk("reset_instruction_1a", {16'h0, instruction_1a}, 64'h0);
            m_fpc = 32'h0;
            m_rpc = 32'h0;
            m_q.delete();
            m_pend.delete();
        end else begin
            kept    = hatch_rvalid && (m_pend.size() > 0) && m_pend[0] && !kill_4a;
            e_req   = !kill_4a && ((m_q.size() + m_pend.size()) < DEPTH);
            byp     = BYP && kept && (m_q.size() == 0);
            e_valid = !kill_4a && ((m_q.size() > 0) || byp);
            e_pc    = (m_q.size() > 0) ? m_q[0] : m_rpc;
            chk("hatch_req", {63'h0, hatch_req}, {63'h0, e_req});
            chk("hatch_address", {32'h0, hatch_address}, {32'h0, m_fpc});
            chk("valid_1a", {63'h0, valid_1a}, {63'h0, e_valid});
            if (e_valid) begin
                chk("pc_1a", {32'h0, pc_1a}, {32'h0, e_pc});
                chk("instruction_1a", {16'h0, instruction_1a}, {16'h0, mem_f(e_pc)});
            end
            if (valid_1a && !stall_2a) begin
                acc_pc.push_back(pc_1a);
                acc_insn.push_back(instruction_1a);
                acc_cyc.push_back(cyc);
            end
            if (hatch_rvalid && m_pend.size() > 0)
                void'(m_pend.pop_front());
            if (kill_4a) begin
                m_q.delete();
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_fpc = branch_target_4a;
                m_rpc = branch_target_4a;
            end else begin
                consumed = e_valid && !stall_2a;
                if (consumed && m_q.size() > 0)
                    void'(m_q.pop_front());
                if (kept) begin
                    if (!(byp && consumed))
                        m_q.push_back(m_rpc);
                    m_rpc = m_rpc + 32'h1;
                end
                if (e_req && hatch_gnt) begin
                    m_pend.push_back(1'b1);
                    m_fpc = m_fpc + 32'h1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0;
        int          kc;
        logic [15:0] pat_s;
        logic [12:0] pat_g;
        pat_s = 16'b0010_1100_0100_0111;
        pat_g = 13'b1_1011_1101_0111;

        // A: reset outputs, then streaming fetch with no stall.
        lat = 1;
        drive(1, 0, 0, 0, 32'h0);
        set_in(1, 1, 0, 0, 32'h0);
        #1;
        chk("A_reset_req_literal", {63'h0, hatch_req}, 64'h0);
        chk("A_reset_valid_literal", {63'h0, valid_1a}, 64'h0);
        end_cycle();
        clear_log();
        r0 = cyc;
        set_in(0, 1, 0, 0, 32'h0);
        #1;
        chk("A_first_req", {63'h0, hatch_req}, 64'h1);
        chk("A_first_addr", {32'h0, hatch_address}, 64'h0);
        end_cycle();
        repeat (11) drive(0, 1, 0, 0, 32'h0);
        chk("A_first_valid_latency", 64'(acy(0) - r0), BYP ? 64'd1 : 64'd2);
        for (int i = 0; i < 4; i++) begin
            chk("A_pc_sequence", accp(i), 64'(i));
            chk("A_consecutive", 64'(acy(i) - acy(0)), 64'(i));
        end
        chk("A_first_insn", acci(0), 64'h0000_0000_DEAD_BEEF);

        // B: decode stalled; fetch fills the queue and stops, then drains.
        drive(1, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        clear_log();
        grants = 0;
        repeat (10) drive(0, 1, 1, 0, 32'h0);
        chk("B_grants", 64'(grants), 64'd4);
        set_in(0, 1, 1, 0, 32'h0);
        #1;
        chk("B_req_low", {63'h0, hatch_req}, 64'h0);
        chk("B_head_valid", {63'h0, valid_1a}, 64'h1);
        chk("B_head_pc", {32'h0, pc_1a}, 64'h0);
        chk("B_none_accepted", 64'(acc_pc.size()), 64'd0);
        end_cycle();
        repeat (12) drive(0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++)
            chk("B_drain_order", accp(i), 64'(i));

        // C: three requests in flight, kill to 0x100; old responses discarded.
        drive(1, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        clear_log();
        lat = 6;
        repeat (3) drive(0, 1, 0, 0, 32'h0);
        chk("C_in_flight", 64'(mem_q.size()), 64'd3);
        drive(0, 0, 0, 1, 32'h100);
        lat = 1;
        set_in(0, 1, 0, 0, 32'h0);
        #1;
        chk("C_post_kill_req", {63'h0, hatch_req}, 64'h1);
        chk("C_post_kill_addr", {32'h0, hatch_address}, 64'h100);
        end_cycle();
        repeat (20) drive(0, 1, 0, 0, 32'h0);
        chk("C_first_pc", accp(0), 64'h100);
        chk("C_second_pc", accp(1), 64'h101);
        chk("C_first_insn", acci(0), 64'h0000_0100_DEAD_BFEF);

        // D: kill together with a response and a stall on a non-empty queue.
        drive(1, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        clear_log();
        lat = 2;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            if (grants >= 3 && mem_q.size() >= 2 && mem_q[0].due <= cyc) break;
            drive(0, 1, 1, 0, 32'h0);
        end
        set_in(0, 1, 1, 1, 32'h200);
        #1;
        chk("D_kill_valid", {63'h0, valid_1a}, 64'h0);
        chk("D_kill_req", {63'h0, hatch_req}, 64'h0);
        end_cycle();
        lat = 1;
        set_in(0, 1, 0, 0, 32'h0);
        #1;
        chk("D_post_kill_req", {63'h0, hatch_req}, 64'h1);
        chk("D_post_kill_addr", {32'h0, hatch_address}, 64'h200);
        end_cycle();
        repeat (15) drive(0, 1, 0, 0, 32'h0);
        chk("D_none_consumed_before", accp(0), 64'h200);
        chk("D_second_pc", accp(1), 64'h201);

        // E: fetch PC wraps from 0xFFFFFFFF to 0; empty-queue response latency.
        drive(1, 0, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        clear_log();
        lat = 1;
        kc = cyc;
        drive(0, 0, 0, 1, 32'hFFFF_FFFF);
        set_in(0, 1, 0, 0, 32'h0);
        #1;
        chk("E_addr_top", {32'h0, hatch_address}, 64'hFFFF_FFFF);
        end_cycle();
        set_in(0, 1, 0, 0, 32'h0);
        #1;
        chk("E_addr_wrap", {32'h0, hatch_address}, 64'h0);
        end_cycle();
        repeat (8) drive(0, 1, 0, 0, 32'h0);
        chk("E_pc_top", accp(0), 64'hFFFF_FFFF);
        chk("E_pc_wrap", accp(1), 64'h0);
        chk("E_valid_latency", 64'(acy(0) - kc), BYP ? 64'd2 : 64'd3);

        // F: mixed grant/stall patterns, varying latency, periodic kills, a mid reset.
        drive(1, 0, 0, 0, 32'h0);
        for (int i = 0; i < 300; i++) begin
            lat = 1 + (i % 3);
            if (i == 150)
                drive(1, 0, 0, 0, 32'h0);
            else if (i % 41 == 40)
                drive(0, pat_g[i % 13], pat_s[i % 16], 1, 32'h1000 + 32'(i) * 32'h10);
            else
                drive(0, pat_g[i % 13], pat_s[i % 16], 0, 32'h0);
        end
        repeat (10) drive(0, 1, 0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
